arty_axi_dram_guard: RTL
========================

ARTY_AXI_DRAM_GUARD -- requirements
Module: arty_axi_dram_guard

Interface
- REQ-001 SHALL take parameter addr_width_p, default 28: AXI address width, equal to the MIG slave port width.
- REQ-002 SHALL take parameter data_width_p, default 64: AXI data width; wstrb is data_width_p/8.
- REQ-003 SHALL take parameter id_width_p, default 4: AXI ID width.
- REQ-004 SHALL take parameter max_outstanding_p, default 4: limit on outstanding bursts per direction.
- REQ-005 SHALL take parameter timeout_cycles_p, default 4096: watchdog limit.
- REQ-006 SHALL have port clk_i, input, 1 bit: the single clock (axi_clk domain).
- REQ-007 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous, active-low.
- REQ-008 SHALL have port calib_done_i, input, 1 bit: MIG init_calib_complete, asynchronous to clk_i.
- REQ-009 SHALL have port bundle s_axi_{aw,w,b,ar,r}*, AXI4 slave, full widths: from bsg_cache_to_axi.
- REQ-010 SHALL have port bundle m_axi_{aw,w,b,ar,r}*, AXI4 master, same widths: to the MIG subsystem.
- REQ-011 SHALL have port rd_error_o, output, 1 bit: sticky flag, nonzero rresp seen.
- REQ-012 SHALL have port wr_error_o, output, 1 bit: sticky flag, nonzero bresp seen.
- REQ-013 SHALL have port timeout_o, output, 1 bit: sticky flag, watchdog expired.
- REQ-014 SHALL have port ready_o, output, 1 bit: high when FSM is in RUN.

Function
- REQ-015 SHALL pass calib_done_i through a 2-flop synchronizer; calib_s below means the synchronized value.
- REQ-016 SHALL implement FSM states WAIT_CALIB, RUN and DRAIN.
  - WAIT_CALIB->RUN when calib_s=1.
  - RUN->DRAIN when calib_s=0.
  - DRAIN->WAIT_CALIB when wr_cnt=0, rd_cnt=0 and wcred=0.
- REQ-017 SHALL pass all payload fields (addr, len, size, burst, id, data, strb, last, resp) combinationally, zero latency; m_axi_awqos and m_axi_arqos SHALL be 0.
- REQ-018 SHALL gate AW and AR: m_axi_awvalid = s_axi_awvalid & RUN & (wr_cnt<max_outstanding_p); s_axi_awready = m_axi_awready & the same gate; AR identical using rd_cnt.
- REQ-019 SHALL count wr_cnt: +1 on AW handshake, -1 on B handshake; simultaneous +1/-1 leaves it unchanged.
- REQ-020 SHALL count rd_cnt: +1 on AR handshake, -1 on R handshake with rlast; simultaneous leaves it unchanged.
- REQ-021 SHALL track W credits wcred: +1 on AW handshake, -1 on W handshake with wlast.
  - W valid/ready SHALL be forwarded only while wcred>0 or an AW handshake occurs in the same cycle.
  - W SHALL continue in DRAIN.
- REQ-022 SHALL pass B and R channels unconditionally in every state.
- REQ-023 SHALL size counters $clog2(max_outstanding_p+1) bits; they SHALL never wrap (the gate guarantees this).
- REQ-024 SHALL set wr_error_o on a B handshake with bresp!=0 and rd_error_o on any R handshake with rresp!=0; both stay set until reset.
- REQ-025 SHALL pass an AW/AR valid held through RUN->DRAIN only if handshaken while the gate was open; no new AW/AR SHALL be accepted in DRAIN or WAIT_CALIB.

Reset
- REQ-026 SHALL, while reset_n_i=0, place the FSM in WAIT_CALIB; clear the synchronizer, counters, wcred, watchdog and all sticky flags; and hold ready_o, s_axi_awready, s_axi_arready, s_axi_wready, m_axi_awvalid, m_axi_arvalid and m_axi_wvalid at 0.
- REQ-027 SHALL let reset assertion mid-burst abandon all tracking immediately; no ordering with the MIG is preserved.

Configuration
- REQ-028 SHALL compile the watchdog only when ARTY_DRAM_GUARD_TIMEOUT_EN is defined.
  - Watchdog counter increments each cycle with (wr_cnt|rd_cnt)!=0 and no B/R handshake; clears otherwise.
  - Reaching timeout_cycles_p-1 sets timeout_o, sticky.
- REQ-029 SHALL, without ARTY_DRAM_GUARD_TIMEOUT_EN, contain no watchdog logic and tie timeout_o to 0.

Verification
- REQ-030 SHALL cover: calib_done_i=0 with s_axi_arvalid=1 for 100 cycles -> m_axi_arvalid=0, ready_o=0; raise calib -> m_axi_arvalid within 3 cycles.
- REQ-031 SHALL cover: 6 back-to-back AR bursts (len=3), MIG R stalled, max_outstanding_p=4 -> exactly 4 AR handshakes, s_axi_arready=0 until first rlast.
- REQ-032 SHALL cover: AW+4 W beats, MIG returns bresp=2'b10 -> wr_error_o=1 and remains 1 after 10 further OKAY writes; rd_error_o=0.
- REQ-033 SHALL cover: 2 reads outstanding, calib drops -> DRAIN, both R bursts delivered, then WAIT_CALIB; new AR not forwarded.
- REQ-034 SHALL cover, with ARTY_DRAM_GUARD_TIMEOUT_EN defined: 1 read outstanding, R withheld -> timeout_o rises after 4096 cycles; without the macro -> timeout_o stays 0.
- REQ-035 SHALL cover: reset_n_i pulsed low mid-write-burst -> all flags and counters 0, FSM WAIT_CALIB.

Source files
------------

// File: rtl/arty_axi_dram_guard.sv
// AXI4 guard between the cache and the MIG: calibration gating, outstanding limits, error flags.
// Optional watchdog on stuck responses: define ARTY_DRAM_GUARD_TIMEOUT_EN.
module arty_axi_dram_guard #(
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 64,
  parameter int id_width_p        = 4,
  parameter int max_outstanding_p = 4,
  parameter int timeout_cycles_p  = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      calib_done_i,

  input  logic [id_width_p-1:0]     s_axi_awid,
  input  logic [addr_width_p-1:0]   s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awlock,
  input  logic [3:0]                s_axi_awcache,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [data_width_p-1:0]   s_axi_wdata,
  input  logic [data_width_p/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [id_width_p-1:0]     s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [id_width_p-1:0]     s_axi_arid,
  input  logic [addr_width_p-1:0]   s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arlock,
  input  logic [3:0]                s_axi_arcache,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [id_width_p-1:0]     s_axi_rid,
  output logic [data_width_p-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,

  output logic [id_width_p-1:0]     m_axi_awid,
  output logic [addr_width_p-1:0]   m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [data_width_p-1:0]   m_axi_wdata,
  output logic [data_width_p/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [id_width_p-1:0]     m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [id_width_p-1:0]     m_axi_arid,
  output logic [addr_width_p-1:0]   m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [id_width_p-1:0]     m_axi_rid,
  input  logic [data_width_p-1:0]   m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,

  output logic                      rd_error_o,
  output logic                      wr_error_o,
  output logic                      timeout_o,
  output logic                      ready_o
);

  localparam int cw_lp = $clog2(max_outstanding_p + 1);
  localparam logic [cw_lp-1:0] max_lp = cw_lp'(max_outstanding_p);
  localparam logic [cw_lp-1:0] one_lp = cw_lp'(1);

  typedef enum logic [1:0] {
    WAIT_CALIB,
    RUN,
    DRAIN
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic             calib_s;
  logic [cw_lp-1:0] wr_cnt_q;
  logic [cw_lp-1:0] rd_cnt_q;
  logic [cw_lp-1:0] wcred_q;

  logic aw_gate, ar_gate;
  logic aw_hs, ar_hs, w_open;
  logic wl_hs, b_hs, r_hs, rl_hs;

  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awlock  = s_axi_awlock;
  assign m_axi_awcache = s_axi_awcache;
  assign m_axi_awprot  = s_axi_awprot;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign s_axi_bid     = m_axi_bid;
  assign s_axi_bresp   = m_axi_bresp;
  assign s_axi_bvalid  = m_axi_bvalid;
  assign m_axi_bready  = s_axi_bready;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_arlock  = s_axi_arlock;
  assign m_axi_arcache = s_axi_arcache;
  assign m_axi_arprot  = s_axi_arprot;
  assign m_axi_arqos   = 4'd0;
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rlast;
  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;

  // Address channels open only in RUN and below the outstanding limit
  assign aw_gate = ready_o & (wr_cnt_q < max_lp);
  assign ar_gate = ready_o & (rd_cnt_q < max_lp);

  assign m_axi_awvalid = s_axi_awvalid & aw_gate;
  assign s_axi_awready = m_axi_awready & aw_gate;
  assign m_axi_arvalid = s_axi_arvalid & ar_gate;
  assign s_axi_arready = m_axi_arready & ar_gate;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;

  // W data may only follow an accepted (or same-cycle) AW
  assign w_open       = (wcred_q != '0) | aw_hs;
  assign m_axi_wvalid = s_axi_wvalid & w_open;
  assign s_axi_wready = m_axi_wready & w_open;

  assign wl_hs = m_axi_wvalid & m_axi_wready & s_axi_wlast;
  assign b_hs  = m_axi_bvalid & s_axi_bready;
  assign r_hs  = m_axi_rvalid & s_axi_rready;
  assign rl_hs = r_hs & m_axi_rlast;

  assign calib_s = sync_q[1];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_q <= 2'b00;
    else            sync_q <= {sync_q[0], calib_done_i};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= WAIT_CALIB;
      ready_o <= 1'b0;
    end else begin
      unique case (state_q)
        WAIT_CALIB: if (calib_s) begin
          state_q <= RUN;
          ready_o <= 1'b1;
        end
        RUN: if (!calib_s) begin
          state_q <= DRAIN;
          ready_o <= 1'b0;
        end
        DRAIN: if (wr_cnt_q == '0 && rd_cnt_q == '0
                   && wcred_q == '0) begin
          state_q <= WAIT_CALIB;
          ready_o <= 1'b0;
        end
        default: begin
          state_q <= WAIT_CALIB;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wcred_q  <= '0;
    end else begin
      if (aw_hs && !b_hs)
        wr_cnt_q <= wr_cnt_q + one_lp;
      else if (!aw_hs && b_hs && wr_cnt_q != '0)
        wr_cnt_q <= wr_cnt_q - one_lp;
      if (ar_hs && !rl_hs)
        rd_cnt_q <= rd_cnt_q + one_lp;
      else if (!ar_hs && rl_hs && rd_cnt_q != '0)
        rd_cnt_q <= rd_cnt_q - one_lp;
      if (aw_hs && !wl_hs)
        wcred_q <= wcred_q + one_lp;
      else if (!aw_hs && wl_hs && wcred_q != '0)
        wcred_q <= wcred_q - one_lp;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_error_o <= 1'b0;
      rd_error_o <= 1'b0;
    end else begin
      if (b_hs && m_axi_bresp != 2'b00) wr_error_o <= 1'b1;
      if (r_hs && m_axi_rresp != 2'b00) rd_error_o <= 1'b1;
    end
  end

`ifdef ARTY_DRAM_GUARD_TIMEOUT_EN
  localparam int ww_lp =
    (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
  localparam logic [ww_lp-1:0] wd_max_lp =
    ww_lp'(timeout_cycles_p - 1);

  logic [ww_lp-1:0] wd_q;
  logic             timeout_q;
  logic             busy;

  assign busy = ((wr_cnt_q | rd_cnt_q) != '0) & ~b_hs & ~r_hs;
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (wd_q == wd_max_lp) timeout_q <= 1'b1;
      if (!busy)                 wd_q <= '0;
      else if (wd_q != wd_max_lp) wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule
